// File: rtl/picosoc_gpio_bank_if.sv
// picosoc_gpio_bank_if: PicoSoC iomem bus bundle for the GPIO bank.
// The master drives the request; the slave returns a one-cycle ready pulse with read data.
interface picosoc_gpio_bank_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/picosoc_gpio_bank.sv
// picosoc_gpio_bank: NUM_PINS-wide memory-mapped GPIO bank on the PicoSoC iomem bus.
// OUT/OE/IN registers, per-pin edge interrupt with W1C status, registered irq.
// Optional input debounce is built only when GPIO_BANK_DEBOUNCE_EN is defined.

// Per-pin input path: synchroniser, optional debounce, edge detector.
module picosoc_gpio_bank_pin
`ifdef GPIO_BANK_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CNT = 4
)
`endif
(
    input  logic clk,
    input  logic resetn,
    input  logic pad_i,
`ifdef GPIO_BANK_DEBOUNCE_EN
    input  logic tick_i,
`endif
    input  logic edge_i,   // 1 = rising, 0 = falling
    input  logic arm_i,    // edge detection enabled once the settle counter saturates
    output logic in_o,
    output logic event_o
);
    logic sync1_q, sync2_q, prev_q;
    logic in_w;

    // Two-flop synchroniser and the one-cycle-delayed copy of IN for edge detection
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            prev_q  <= in_w;
        end
    end

`ifdef GPIO_BANK_DEBOUNCE_EN
    logic [3:0] cnt_q, cnt_d;
    logic       in_q, in_d;

    // Count ticks on which the synchronised level disagrees with IN; accept after DEBOUNCE_CNT in a row
    always_comb begin
        cnt_d = cnt_q;
        in_d  = in_q;
        if (tick_i) begin
            if (sync2_q != in_q) begin
                if (cnt_q + 4'd1 == 4'(DEBOUNCE_CNT)) begin
                    in_d  = sync2_q;
                    cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cnt_d = 4'd0;
            end
        end
    end

    // Debounce state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= 4'd0;
            in_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            in_q  <= in_d;
        end
    end

    assign in_w = in_q;
`else
    assign in_w = sync2_q;
`endif

    assign in_o    = in_w;
    assign event_o = arm_i & (edge_i ? (in_w & ~prev_q) : (~in_w & prev_q));
endmodule

// Bus decode, register file, interrupt status and irq.
module picosoc_gpio_bank #(
    parameter int          NUM_PINS     = 16,
    parameter logic [7:0]  ADDR_BASE    = 8'h07,
    parameter int          DEBOUNCE_DIV = 1200,
    parameter int          DEBOUNCE_CNT = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    picosoc_gpio_bank_if.slave    bus,
    input  logic [NUM_PINS-1:0]   gpio_in,
    output logic [NUM_PINS-1:0]   gpio_out,
    output logic [NUM_PINS-1:0]   gpio_oe,
    output logic                  irq
);
    // Elaboration-time parameter range checks
    if (NUM_PINS < 1 || NUM_PINS > 32) begin : g_bad_pins
        $error("picosoc_gpio_bank: NUM_PINS must be 1..32");
    end
    if (DEBOUNCE_DIV < 2 || DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15) begin : g_bad_db
        $error("picosoc_gpio_bank: DEBOUNCE_DIV must be >=2 and DEBOUNCE_CNT 1..15");
    end

    localparam logic [2:0] R_OUT = 3'd0, R_OE = 3'd1, R_IN = 3'd2,
                           R_EN  = 3'd3, R_EDGE = 3'd4, R_STAT = 3'd5;

    logic [NUM_PINS-1:0] out_q, out_d, oe_q, oe_d, en_q, en_d;
    logic [NUM_PINS-1:0] edge_q, edge_d, stat_q, stat_d;
    logic [NUM_PINS-1:0] in_w, evt_w;
    logic                ready_q;
    logic [31:0]         rdata_q, rd_d;
    logic                irq_q;
    logic [1:0]          settle_q, settle_d;
    logic                arm;

    logic                accept, wr;
    logic [2:0]          sel;
    logic [31:0]         wmask;
    logic [NUM_PINS-1:0] wmask_p, wdata_m;

    // Ready gating forces an idle cycle between back-to-back accesses
    assign accept  = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:24] == ADDR_BASE);
    assign wr      = accept && (bus.iomem_wstrb != 4'd0);
    assign sel     = bus.iomem_addr[4:2];
    assign wmask   = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                      {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
    assign wmask_p = wmask[NUM_PINS-1:0];
    assign wdata_m = bus.iomem_wdata[NUM_PINS-1:0] & wmask_p;
    assign arm     = (settle_q == 2'd3);

    // Bits of the bus that never affect state
    logic unused_bits;
    assign unused_bits = ^{bus.iomem_addr[23:5], bus.iomem_addr[1:0], bus.iomem_wdata};

`ifdef GPIO_BANK_DEBOUNCE_EN
    localparam int PW = $clog2(DEBOUNCE_DIV);
    logic [PW-1:0] presc_q;
    logic          tick;

    assign tick = (presc_q == PW'(DEBOUNCE_DIV - 1));

    // Free-running prescaler producing one debounce tick every DEBOUNCE_DIV cycles
    always_ff @(posedge clk) begin
        if (!resetn) presc_q <= '0;
        else         presc_q <= tick ? '0 : presc_q + PW'(1);
    end
`endif

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        picosoc_gpio_bank_pin
`ifdef GPIO_BANK_DEBOUNCE_EN
            #(.DEBOUNCE_CNT(DEBOUNCE_CNT))
`endif
        u_pin (
            .clk     (clk),
            .resetn  (resetn),
            .pad_i   (gpio_in[p]),
`ifdef GPIO_BANK_DEBOUNCE_EN
            .tick_i  (tick),
`endif
            .edge_i  (edge_q[p]),
            .arm_i   (arm),
            .in_o    (in_w[p]),
            .event_o (evt_w[p])
        );
    end

    // Read mux: pre-write register values, unused high bits and reserved slots read 0
    always_comb begin
        rd_d = '0;
        case (sel)
            R_OUT:   rd_d[NUM_PINS-1:0] = out_q;
            R_OE:    rd_d[NUM_PINS-1:0] = oe_q;
            R_IN:    rd_d[NUM_PINS-1:0] = in_w;
            R_EN:    rd_d[NUM_PINS-1:0] = en_q;
            R_EDGE:  rd_d[NUM_PINS-1:0] = edge_q;
            R_STAT:  rd_d[NUM_PINS-1:0] = stat_q;
            default: rd_d = '0;
        endcase
    end

    // Register next-state: byte-masked writes, W1C status where a same-cycle event wins
    always_comb begin
        out_d    = out_q;
        oe_d     = oe_q;
        en_d     = en_q;
        edge_d   = edge_q;
        stat_d   = stat_q;
        settle_d = arm ? settle_q : settle_q + 2'd1;
        if (wr) begin
            case (sel)
                R_OUT:   out_d  = (out_q  & ~wmask_p) | wdata_m;
                R_OE:    oe_d   = (oe_q   & ~wmask_p) | wdata_m;
                R_EN:    en_d   = (en_q   & ~wmask_p) | wdata_m;
                R_EDGE:  edge_d = (edge_q & ~wmask_p) | wdata_m;
                R_STAT:  stat_d = stat_q & ~wdata_m;
                default: ;
            endcase
        end
        stat_d = stat_d | evt_w;
    end

    // State registers, bus response and registered irq
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_q    <= '0;
            oe_q     <= '0;
            en_q     <= '0;
            edge_q   <= '0;
            stat_q   <= '0;
            settle_q <= 2'd0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            oe_q     <= oe_d;
            en_q     <= en_d;
            edge_q   <= edge_d;
            stat_q   <= stat_d;
            settle_q <= settle_d;
            ready_q  <= accept;
            rdata_q  <= accept ? rd_d : '0;
            irq_q    <= |(stat_q & en_q);
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign gpio_out        = out_q;
    assign gpio_oe         = oe_q;
    assign irq             = irq_q;
endmodule

// File: tb/tb_picosoc_gpio_bank.sv
// tb_picosoc_gpio_bank: directed stimulus with a scoreboard; a monitor compares
// every ready pulse against queued expected read data and drains queued pin checks.
module tb_picosoc_gpio_bank;
`ifdef GPIO_BANK_DEBOUNCE_EN
    localparam int DIV = 4, CNT = 3, WAITC = 20;
`else
    localparam int DIV = 1200, CNT = 4, WAITC = 6;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] gpio_in = 16'h00FF;
    logic [15:0] gpio_out, gpio_oe;
    logic        irq;

    picosoc_gpio_bank_if bus ();

    picosoc_gpio_bank #(
        .NUM_PINS(16), .ADDR_BASE(8'h07), .DEBOUNCE_DIV(DIV), .DEBOUNCE_CNT(CNT)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct { string name; logic [31:0] want; } exp_t;
    typedef struct { string name; logic [31:0] act; logic [31:0] want; } chk_t;

    exp_t rq[$];
    chk_t cq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done = 1'b0;

    // Monitor: all comparisons happen here, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        chk_t c;
        if (bus.iomem_ready === 1'b1) begin
            n_cmp++;
            if (rq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ready: got ready=1 with nothing outstanding, required 0");
            end else begin
                e = rq.pop_front();
                if (bus.iomem_rdata !== e.want) begin
                    n_bad++;
                    $display("FAIL %s: rdata got %h required %h", e.name, bus.iomem_rdata, e.want);
                end
            end
        end
        while (cq.size() > 0) begin
            c = cq.pop_front();
            n_cmp++;
            if (c.act !== c.want) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", c.name, c.act, c.want);
            end
        end
        if (done) begin
            n_cmp++;
            if (rq.size() != 0) begin
                n_bad++;
                $display("FAIL pending_reads: got %0d outstanding required 0", rq.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] w);
        cq.push_back('{name: n, act: a, want: w});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus access; want is the register value from before any write
    task automatic acc(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input logic [31:0] w, input string n);
        bit got;
        rq.push_back('{name: n, want: w});
        @(posedge clk); #1;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = a;
        bus.iomem_wstrb = s;
        bus.iomem_wdata = d;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.iomem_ready === 1'b1) got = 1'b1;
        end
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'd0;
        if (!got) chk({n, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        bit seen;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'd0;
        bus.iomem_addr  = 32'd0;
        bus.iomem_wdata = 32'd0;

        // Reset state
        cyc(3);
        chk("rst_gpio_out", {16'd0, gpio_out}, 32'd0);
        chk("rst_gpio_oe", {16'd0, gpio_oe}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_ready", {31'd0, bus.iomem_ready}, 32'd0);
        chk("rst_rdata", bus.iomem_rdata, 32'd0);
        resetn = 1'b1;
        cyc(WAITC);

        // Pins high through reset produce no false edges
        acc(32'h0700_0008, 4'h0, 32'd0, 32'h0000_00FF, "in_after_reset");
        acc(32'h0700_0014, 4'h0, 32'd0, 32'd0, "status_after_reset");
        chk("irq_after_reset", {31'd0, irq}, 32'd0);

        // OUT with byte strobes and pin-width masking
        acc(32'h0700_0000, 4'b0001, 32'hA5A5_1234, 32'd0, "out_wr_b0");
        chk("gpio_out_b0", {16'd0, gpio_out}, 32'h0000_0034);
        acc(32'h0700_0000, 4'h0, 32'd0, 32'h0000_0034, "out_rd_b0");
        acc(32'h0700_0000, 4'b0010, 32'hFFFF_AB00, 32'h0000_0034, "out_wr_b1");
        chk("gpio_out_b1", {16'd0, gpio_out}, 32'h0000_AB34);
        acc(32'h0700_0000, 4'h0, 32'd0, 32'h0000_AB34, "out_rd_b1");

        // OE
        acc(32'h0700_0004, 4'hF, 32'h0000_FFFF, 32'd0, "oe_wr");
        chk("gpio_oe_on", {16'd0, gpio_oe}, 32'h0000_FFFF);
        acc(32'h0700_0004, 4'h0, 32'd0, 32'h0000_FFFF, "oe_rd");
        acc(32'h0700_0004, 4'hF, 32'd0, 32'h0000_FFFF, "oe_clr");

        // Falling edges set status even with IRQ_EN=0
        gpio_in = 16'h0000;
        cyc(WAITC);
        acc(32'h0700_0008, 4'h0, 32'd0, 32'd0, "in_low");
        acc(32'h0700_0014, 4'h0, 32'd0, 32'h0000_00FF, "status_fall");
        chk("irq_masked", {31'd0, irq}, 32'd0);
        acc(32'h0700_0014, 4'hF, 32'h0000_00FF, 32'h0000_00FF, "status_w1c");
        acc(32'h0700_0014, 4'h0, 32'd0, 32'd0, "status_cleared");

        // Rising edge interrupt on pin 0
        acc(32'h0700_0010, 4'hF, 32'd1, 32'd0, "edge_wr");
        acc(32'h0700_000C, 4'hF, 32'd1, 32'd0, "en_wr");
        gpio_in = 16'h0001;
        cyc(WAITC);
        chk("irq_rise", {31'd0, irq}, 32'd1);
        acc(32'h0700_0014, 4'h0, 32'd0, 32'd1, "status_rise");
        acc(32'h0700_0014, 4'hF, 32'd1, 32'd1, "status_w1c_pin0");
        cyc(1);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

`ifndef GPIO_BANK_DEBOUNCE_EN
        // Event and W1C on the same edge: set wins
        gpio_in = 16'h0000;
        cyc(WAITC);
        gpio_in = 16'h0001;
        cyc(1);
        acc(32'h0700_0014, 4'hF, 32'd1, 32'd0, "setwins_w1c");
        acc(32'h0700_0014, 4'h0, 32'd0, 32'd1, "setwins_status");
        acc(32'h0700_0014, 4'hF, 32'd1, 32'd1, "setwins_clear");
`endif

        // Changing EDGE leaves status alone
        acc(32'h0700_0010, 4'hF, 32'd0, 32'd1, "edge_back");
        acc(32'h0700_0014, 4'h0, 32'd0, 32'd0, "status_after_edge");

        // Non-matching base: no ready, no write
        seen = 1'b0;
        @(posedge clk); #1;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = 32'h0800_0000;
        bus.iomem_wstrb = 4'hF;
        bus.iomem_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.iomem_ready === 1'b1) seen = 1'b1;
        end
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'd0;
        chk("nomatch_ready", {31'd0, seen}, 32'd0);
        acc(32'h07FF_FF00, 4'h0, 32'd0, 32'h0000_AB34, "out_alias_unchanged");

        // Reserved slots
        acc(32'h0700_001C, 4'hF, 32'hFFFF_FFFF, 32'd0, "rsvd_wr");
        acc(32'h0700_001C, 4'h0, 32'd0, 32'd0, "rsvd_rd_1c");
        acc(32'h0700_0018, 4'h0, 32'd0, 32'd0, "rsvd_rd_18");

        // Pin 0 falling with EDGE=0 sets status bit 0
        gpio_in = 16'h0000;
        cyc(WAITC);
        acc(32'h0700_0014, 4'hF, 32'h0000_FFFF, 32'd1, "fall_status_w1c");

`ifdef GPIO_BANK_DEBOUNCE_EN
        // Short glitch is filtered, long level is accepted
        acc(32'h0700_0010, 4'hF, 32'd2, 32'd0, "db_edge_wr");
        gpio_in = 16'h0002;
        cyc(6);
        gpio_in = 16'h0000;
        cyc(20);
        acc(32'h0700_0008, 4'h0, 32'd0, 32'd0, "db_glitch_in");
        acc(32'h0700_0014, 4'h0, 32'd0, 32'd0, "db_glitch_status");
        gpio_in = 16'h0002;
        cyc(20);
        acc(32'h0700_0008, 4'h0, 32'd0, 32'd2, "db_hold_in");
        acc(32'h0700_0014, 4'h0, 32'd0, 32'd2, "db_hold_status");
`endif

        cyc(2);
        done = 1'b1;
    end
endmodule

// File: doc/picosoc_gpio_bank.md
Name: picosoc_gpio_bank

Overview:
Parametrised memory-mapped GPIO peripheral on the PicoSoC iomem bus. It replaces fixed single-register GPIO/MMIO decoding with a bank of NUM_PINS bidirectional pins, each with:
- output, output-enable and synchronised input registers;
- per-pin edge-triggered interrupt with write-1-to-clear status.
It sits in the board top level, selected when iomem_addr[31:24] equals ADDR_BASE. Its irq output drives one of the SoC irq_5..irq_7 lines.

Parameters:
NUM_PINS, 16, number of GPIO pins (1..32); register bits above NUM_PINS-1 read 0 and ignore writes
ADDR_BASE, 8'h07, value of iomem_addr[31:24] that selects this block
DEBOUNCE_DIV, 1200, clk cycles per debounce sample tick (>=2); used only with the debounce macro
DEBOUNCE_CNT, 4, consecutive stable ticks needed to accept a new level (1..15); used only with the debounce macro

Ports:
clk  input  1  system clock
resetn  input  1  synchronous, active-low reset
iomem_valid  input  1  bus request valid
iomem_ready  output  1  one-cycle completion pulse
iomem_wstrb  input  4  byte write strobes; 0 = read
iomem_addr  input  32  byte address
iomem_wdata  input  32  write data
iomem_rdata  output  32  read data, valid while iomem_ready=1
gpio_in  input  NUM_PINS  raw asynchronous pad inputs
gpio_out  output  NUM_PINS  pad output values (OUT register)
gpio_oe  output  NUM_PINS  pad output enables, 1 = drive (OE register)
irq  output  1  level interrupt = |(IRQ_STATUS & IRQ_EN)

Behaviour:
- Reset (resetn=0 at posedge clk) clears everything to 0:
  - all registers, sync flops, debounce state and the settle counter;
  - outputs: iomem_ready=0, iomem_rdata=0, gpio_out=0, gpio_oe=0 (all pins inputs), irq=0.
  - Reset mid-transaction drops the transaction; no ready pulse is issued for it.
- Register map, decoded on iomem_addr[4:2]; iomem_addr[23:5] is ignored:
  - 0x00 OUT (rw)
  - 0x04 OE (rw)
  - 0x08 IN (ro): synchronised (or debounced) pin level
  - 0x0C IRQ_EN (rw)
  - 0x10 EDGE (rw): 1 = rising, 0 = falling
  - 0x14 IRQ_STATUS (w1c)
  - 0x18, 0x1C: reserved; read 0, writes ignored, still acknowledged
- Handshake:
  - A cycle with iomem_valid && !iomem_ready && addr[31:24]==ADDR_BASE is accepted.
  - At the next posedge: iomem_ready=1 for exactly one cycle, and iomem_rdata holds the register value from before the write.
  - Writes take effect at that same edge; each wstrb[k] gates byte k.
  - Latency 1 cycle. Back-to-back accesses complete at most every 2nd cycle.
  - Non-matching addresses: no ready, no state change.
- Input path:
  - Two-flop synchroniser per pin gives sync_in.
  - Without the debounce macro, IN = sync_in.
  - prev_in holds IN delayed one cycle.
- Edge detect:
  - rise = IN & ~prev_in; fall = ~IN & prev_in.
  - Event = EDGE ? rise : fall.
  - Detection is masked until a 2-bit settle counter, started at reset release, saturates at 3. This prevents false edges from pins already high at reset.
- IRQ_STATUS:
  - A bit is set on an event regardless of IRQ_EN.
  - Writing 1 clears a bit; writing 0 has no effect.
  - An event and a W1C on the same bit in the same cycle leave the bit set (set wins).
  - irq is registered: it follows status/enable changes with 1 cycle latency.
- Changing EDGE or IRQ_EN never modifies IRQ_STATUS.
- OUT and OE apply to gpio_out/gpio_oe at the edge the write takes effect.
- IN reads the pad regardless of OE, so it reflects loopback when the pad is driven.

Optional Feature:
GPIO_BANK_DEBOUNCE_EN
- Defined:
  - A free-running prescaler produces a one-cycle tick every DEBOUNCE_DIV cycles.
  - Per pin, a 4-bit counter counts ticks on which sync_in != IN, and resets to 0 on any tick where sync_in == IN.
  - When the count reaches DEBOUNCE_CNT, IN takes sync_in and the counter clears.
  - Glitches shorter than DEBOUNCE_CNT ticks never reach IN or the edge detector.
  - Prescaler and counters reset to 0.
- Undefined: no prescaler or counters are built; IN = sync_in; the DEBOUNCE_* parameters are unused.

Test Plan:
- Reset, then read 0x07000008 with gpio_in=16'h00FF -> rdata=32'h000000FF; irq=0 and IRQ_STATUS=0 (no false rising edges).
- Write 0x07000000 wdata=32'hA5A5_1234 wstrb=4'b0001 -> ready one cycle later, gpio_out=16'h0034; readback 0x00 = 32'h00000034 (NUM_PINS=16 masks upper bits).
- Set EDGE=16'h0001 and IRQ_EN=16'h0001, drive gpio_in[0] 0->1 -> IRQ_STATUS[0]=1 within 4 cycles (no debounce), irq=1; write 0x07000014 wdata=1 -> irq=0 next cycle.
- Rising edge on pin 0 in the same cycle as a W1C write of bit 0 -> IRQ_STATUS[0] stays 1.
- With GPIO_BANK_DEBOUNCE_EN, DEBOUNCE_DIV=4, DEBOUNCE_CNT=3: a 6-cycle high pulse on gpio_in[1] -> IN[1] stays 0, no status set; holding it high 20 cycles -> IN[1]=1 and a rising event.
- Access to 0x08000000 -> no ready for 10 cycles, no state change; access to 0x0700001C -> ready, rdata=0.
